demux_rr_n: RTL and testbench



---
 rtl/demux_pkg.sv | 12 +
 rtl/demux_ch_reg.sv | 35 +++
 rtl/demux_rr_n.sv | 81 ++++++++
 tb/tb_demux_rr_n.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// Shared defaults and routing-mode encoding for the 1:N demultiplexer.
package demux_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 8;
  localparam int unsigned DEF_NUM_CH     = 4;

  typedef enum logic {
    MODE_RR  = 1'b0,
    MODE_SEL = 1'b1
  } mode_e;

endpackage

// File: rtl/demux_ch_reg.sv
// One-entry output register for a single demux channel.
// A load always wins over a drain, so a word taken by the consumer in the
// same cycle a new word arrives is replaced without a bubble.
module demux_ch_reg #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset_L,
  input  logic                  i_load,
  input  logic                  i_drain,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid
);

  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_valid;

  // Hold the word; reload on load, clear valid on drain, data kept on drain.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_data  <= i_data;
      r_valid <= 1'b1;
    end else if (i_drain) begin
      r_valid <= 1'b0;
    end
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;

endmodule

// File: rtl/demux_rr_n.sv
// 1:N valid/ready demultiplexer with round-robin or explicit channel select.
// Round-robin is strictly ordered: a full target stalls the input rather
// than skipping to a free channel.
module demux_rr_n
  import demux_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter  int unsigned NUM_CH     = DEF_NUM_CH,
  localparam int unsigned SEL_W      = $clog2(NUM_CH)
) (
  input  logic                         clk,
  input  logic                         reset_L,
  input  logic [DATA_WIDTH-1:0]        data_in,
  input  logic                         valid_in,
  output logic                         ready_out,
  input  logic                         mode_in,
  input  logic [SEL_W-1:0]             sel_in,
  output logic [NUM_CH*DATA_WIDTH-1:0] data_out,
  output logic [NUM_CH-1:0]            valid_out,
  input  logic [NUM_CH-1:0]            ready_in,
  output logic [SEL_W-1:0]             rr_ptr_out
);

  logic [SEL_W-1:0]  r_rr_ptr;
  mode_e             w_mode;
  logic [SEL_W-1:0]  w_tgt;
  logic              w_accept;
  logic [NUM_CH-1:0] w_load;
  logic [NUM_CH-1:0] w_drain;
  logic [NUM_CH-1:0] w_valid;

  assign w_mode   = mode_e'(mode_in);
  assign w_tgt    = (w_mode == MODE_SEL) ? sel_in : r_rr_ptr;
  assign ready_out = !w_valid[w_tgt] || ready_in[w_tgt];
  assign w_accept = valid_in && ready_out;

  // Decode the accepted word onto its target channel; drains are per channel.
  always_comb begin
    w_load  = '0;
    w_drain = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      w_load[i]  = w_accept && (w_tgt == SEL_W'(i));
      w_drain[i] = w_valid[i] && ready_in[i];
    end
  end

  // Round-robin pointer advances only on a round-robin accept.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_rr_ptr <= '0;
    end else if (w_accept && (w_mode == MODE_RR)) begin
      if (r_rr_ptr == SEL_W'(NUM_CH - 1)) begin
        r_rr_ptr <= '0;
      end else begin
        r_rr_ptr <= r_rr_ptr + SEL_W'(1);
      end
    end
  end

  assign rr_ptr_out = r_rr_ptr;
  assign valid_out  = w_valid;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [DATA_WIDTH-1:0] w_ch_data;

    demux_ch_reg #(
      .DATA_WIDTH (DATA_WIDTH)
    ) u_ch_reg (
      .clk     (clk),
      .reset_L (reset_L),
      .i_load  (w_load[g]),
      .i_drain (w_drain[g]),
      .i_data  (data_in),
      .o_data  (w_ch_data),
      .o_valid (w_valid[g])
    );

    assign data_out[g*DATA_WIDTH +: DATA_WIDTH] = w_ch_data;
  end

endmodule

// File: tb/tb_demux_rr_n.sv
// Directed bench for demux_rr_n (NUM_CH=4, DATA_WIDTH=8) with a per-cycle
// behavioural model and hand-computed literal checks.
module tb_demux_rr_n;

  localparam int unsigned DW = 8;
  localparam int unsigned NC = 4;

  logic          clk = 1'b0;
  logic          reset_L = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic          valid_in = 1'b0;
  logic          ready_out;
  logic          mode_in = 1'b0;
  logic [1:0]    sel_in = '0;
  logic [NC*DW-1:0] data_out;
  logic [NC-1:0] valid_out;
  logic [NC-1:0] ready_in = '0;
  logic [1:0]    rr_ptr_out;

  int unsigned total = 0;
  int unsigned bad   = 0;

  demux_rr_n #(
    .DATA_WIDTH (DW),
    .NUM_CH     (NC)
  ) dut (
    .clk        (clk),
    .reset_L    (reset_L),
    .data_in    (data_in),
    .valid_in   (valid_in),
    .ready_out  (ready_out),
    .mode_in    (mode_in),
    .sel_in     (sel_in),
    .data_out   (data_out),
    .valid_out  (valid_out),
    .ready_in   (ready_in),
    .rr_ptr_out (rr_ptr_out)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  int unsigned m_data [NC];
  bit          m_full [NC];
  int unsigned m_ptr;

  initial begin
    for (int i = 0; i < NC; i++) begin
      m_data[i] = 0;
      m_full[i] = 0;
    end
    m_ptr = 0;
  end

  function automatic void model_clear();
    for (int i = 0; i < NC; i++) begin
      m_data[i] = 0;
      m_full[i] = 0;
    end
    m_ptr = 0;
  endfunction

  function automatic int unsigned model_target();
    return mode_in ? int'(sel_in) : m_ptr;
  endfunction

  function automatic bit model_ready();
    int unsigned t;
    t = model_target();
    return !m_full[t] || ready_in[t];
  endfunction

  always @(negedge reset_L) model_clear();

  always @(posedge clk) begin
    int unsigned t;
    bit acc;
    if (!reset_L) begin
      model_clear();
    end else begin
      t   = model_target();
      acc = valid_in && model_ready();
      for (int i = 0; i < NC; i++)
        if (m_full[i] && ready_in[i]) m_full[i] = 0;
      if (acc) begin
        m_data[t] = data_in;
        m_full[t] = 1;
        if (!mode_in) m_ptr = (m_ptr + 1) % NC;
      end
    end
  end

  // ---------------- checking ----------------
  function automatic void chk(input string name, input int unsigned act,
                              input int unsigned exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic int unsigned ch_data(input int unsigned ch);
    logic [NC*DW-1:0] v;
    v = data_out;
    return int'(v[ch*DW +: DW]);
  endfunction

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    int unsigned mv;
    mv = 0;
    for (int i = 0; i < NC; i++) begin
      if (m_full[i]) mv |= (1 << i);
      chk($sformatf("model_data%0d", i), ch_data(i), m_data[i]);
    end
    chk("model_valid", int'(valid_out), mv);
    chk("model_ptr", int'(rr_ptr_out), m_ptr);
    chk("model_ready", int'(ready_out), int'(model_ready()));
  end

  // ---------------- stimulus ----------------
  // Present a word and hold it until accepted; returns at posedge+1 after
  // the accepting edge, with the number of stalled cycles.
  task automatic send(input logic [DW-1:0] d, input logic m, input logic [1:0] s,
                      output int unsigned waits);
    data_in  = d;
    mode_in  = m;
    sel_in   = s;
    valid_in = 1'b1;
    waits    = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (ready_out) begin
        @(posedge clk);
        #1;
        return;
      end
      waits++;
    end
    total++;
    bad++;
    $display("FAIL send_timeout: word 0x%0h never accepted", d);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int unsigned n);
    valid_in = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int unsigned w;

    // Reset, then round-robin streaming.
    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid", int'(valid_out), 0);
    chk("reset_data", int'(data_out), 0);
    chk("reset_ptr", int'(rr_ptr_out), 0);
    reset_L  = 1'b1;
    ready_in = 4'hF;
    for (int k = 0; k < 8; k++) begin
      send(8'hA0 + 8'(k), 1'b0, 2'd0, w);
      chk("rr_nostall", w, 0);
      chk($sformatf("rr_data_k%0d", k), ch_data(k % 4), 32'hA0 + k);
      chk($sformatf("rr_valid_k%0d", k), int'(valid_out[k % 4]), 1);
    end
    chk("rr_ptr_end", int'(rr_ptr_out), 0);
    idle(1);

    // Explicit select to channel 2.
    send(8'h11, 1'b1, 2'd2, w);
    chk("sel_valid_11", int'(valid_out), 32'h4);
    chk("sel_data_11", ch_data(2), 32'h11);
    send(8'h22, 1'b1, 2'd2, w);
    chk("sel_data_22", ch_data(2), 32'h22);
    send(8'h33, 1'b1, 2'd2, w);
    chk("sel_valid_33", int'(valid_out), 32'h4);
    chk("sel_data_33", ch_data(2), 32'h33);
    chk("sel_ptr", int'(rr_ptr_out), 0);
    idle(1);

    // Backpressure on channel 0.
    ready_in = 4'b1110;
    send(8'h55, 1'b0, 2'd0, w);
    send(8'h66, 1'b0, 2'd0, w);
    chk("bp_ch1", ch_data(1), 32'h66);
    chk("bp_ptr2", int'(rr_ptr_out), 2);
    send(8'h77, 1'b0, 2'd0, w);
    send(8'h88, 1'b0, 2'd0, w);
    data_in  = 8'h99;
    valid_in = 1'b1;
    @(negedge clk);
    chk("bp_stall_ready", int'(ready_out), 0);
    chk("bp_stall_ptr", int'(rr_ptr_out), 0);
    chk("bp_ch0_held", ch_data(0), 32'h55);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("bp_stall_ready2", int'(ready_out), 0);
    @(posedge clk);
    #1;
    ready_in = 4'hF;
    send(8'h99, 1'b0, 2'd0, w);
    chk("bp_release_wait", w, 0);
    ready_in = 4'b1110;
    chk("bp_ch0_99", ch_data(0), 32'h99);
    chk("bp_v0_stays", int'(valid_out[0]), 1);
    chk("bp_ptr1", int'(rr_ptr_out), 1);
    ready_in = 4'hF;
    idle(1);

    // Simultaneous drain and reload on channel 1.
    send(8'hC1, 1'b1, 2'd1, w);
    chk("dr_c1", ch_data(1), 32'hC1);
    send(8'hC2, 1'b1, 2'd1, w);
    chk("dr_wait_c2", w, 0);
    chk("dr_v1_c2", int'(valid_out[1]), 1);
    chk("dr_c2", ch_data(1), 32'hC2);
    send(8'hC3, 1'b1, 2'd1, w);
    chk("dr_wait_c3", w, 0);
    chk("dr_v1_c3", int'(valid_out[1]), 1);
    chk("dr_c3", ch_data(1), 32'hC3);
    idle(1);

    // Fill all channels, then reset between edges.
    ready_in = 4'h0;
    send(8'hE1, 1'b0, 2'd0, w);
    send(8'hE2, 1'b0, 2'd0, w);
    send(8'hE3, 1'b0, 2'd0, w);
    send(8'hE0, 1'b0, 2'd0, w);
    valid_in = 1'b0;
    chk("full_valid", int'(valid_out), 32'hF);
    #3;
    reset_L = 1'b0;
    #1;
    chk("mid_reset_valid", int'(valid_out), 0);
    chk("mid_reset_data", int'(data_out), 0);
    chk("mid_reset_ptr", int'(rr_ptr_out), 0);
    @(posedge clk);
    #1;
    reset_L  = 1'b1;
    ready_in = 4'hF;
    send(8'hF0, 1'b0, 2'd0, w);
    chk("post_reset_valid", int'(valid_out), 32'h1);
    chk("post_reset_ch0", ch_data(0), 32'hF0);

    // Mode switch keeps the round-robin pointer.
    send(8'hF1, 1'b0, 2'd0, w);
    chk("ms_ptr2", int'(rr_ptr_out), 2);
    send(8'h5A, 1'b1, 2'd0, w);
    chk("ms_sel_ch0", ch_data(0), 32'h5A);
    chk("ms_ptr_held", int'(rr_ptr_out), 2);
    send(8'h6B, 1'b0, 2'd0, w);
    chk("ms_resume_ch2", ch_data(2), 32'h6B);
    chk("ms_resume_v", int'(valid_out), 32'h4);
    chk("ms_ptr3", int'(rr_ptr_out), 3);
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time bound so the run can never hang.
  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "timeout");
  end

endmodule
